hazard_ctrl: RTL and testbench



---
 rtl/hazard_ctrl.sv | 119 +++++++++++
 tb/tb_hazard_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32 core: register enables,
// bubble flushes, mul/div occupancy FSM and a stall-cycle performance counter.
module hazard_ctrl #(
  parameter int MD_CYCLES  = 4,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_md_start,
  input  logic                  ex_branch_taken,
  input  logic                  mem_req,
  input  logic                  dmem_ready,
  output logic                  pc_wr_en,
  output logic                  ifid_wr_en,
  output logic                  idex_wr_en,
  output logic                  exmem_wr_en,
  output logic                  memwb_wr_en,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  exmem_flush,
  output logic                  md_busy,
  output logic                  md_done,
  output logic [CNT_W-1:0]      stall_cnt
);

  typedef enum logic {RUN = 1'b0, MD_BUSY = 1'b1} state_t;

  state_t     state, state_nxt;
  logic [7:0] md_cnt, md_cnt_nxt;

  logic freeze, md_stall, md_rel, load_use;

  assign freeze   = mem_req && !dmem_ready;
  assign md_stall = (state == RUN && ex_md_start) || (state == MD_BUSY && md_cnt != 8'd0);
  assign md_rel   = (state == MD_BUSY) && (md_cnt == 8'd0);
  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));

  // State register; reset mid-op simply abandons the mul/div.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= RUN;
      md_cnt    <= 8'd0;
      stall_cnt <= '0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
      if (!pc_wr_en) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  // Start cycle counts as one of MD_CYCLES, release cycle as another.
  always_comb begin
    state_nxt  = state;
    md_cnt_nxt = md_cnt;
    if (!freeze) begin
      if (md_stall) begin
        if (state == RUN) begin
          state_nxt  = MD_BUSY;
          md_cnt_nxt = 8'(MD_CYCLES - 2);
        end else begin
          md_cnt_nxt = md_cnt - 8'd1;
        end
      end else if (md_rel) begin
        state_nxt = RUN;
      end
    end
  end

  always_comb begin
    pc_wr_en    = 1'b1;
    ifid_wr_en  = 1'b1;
    idex_wr_en  = 1'b1;
    exmem_wr_en = 1'b1;
    memwb_wr_en = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    md_busy     = (state == MD_BUSY);
    md_done     = 1'b0;
    if (!rst) begin
      pc_wr_en    = 1'b0;
      ifid_wr_en  = 1'b0;
      idex_wr_en  = 1'b0;
      exmem_wr_en = 1'b0;
      memwb_wr_en = 1'b0;
      md_busy     = 1'b0;
    end else if (freeze) begin
      pc_wr_en    = 1'b0;
      ifid_wr_en  = 1'b0;
      idex_wr_en  = 1'b0;
      exmem_wr_en = 1'b0;
      memwb_wr_en = 1'b0;
    end else if (md_stall) begin
      // Hold the front end, push a bubble out of EX behind the mul/div.
      pc_wr_en    = 1'b0;
      ifid_wr_en  = 1'b0;
      idex_wr_en  = 1'b0;
      exmem_flush = 1'b1;
    end else if (md_rel) begin
      md_done = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_wr_en   = 1'b0;
      ifid_wr_en = 1'b0;
      idex_flush = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: constant vector table, hand sequences for the
// multi-cycle cases, then random traffic against a cycle-age reference model.
module tb_hazard_ctrl;
  localparam int MD = 4;

  typedef struct packed {
    logic [4:0] rs1, rs2;
    logic       use1, use2;
    logic [4:0] rd;
    logic       mem_read, md_start, br, mem_req, dready;
  } in_t;

  typedef struct {
    in_t        i;
    logic [9:0] e;
    string      nm;
  } vec_t;

  // {pc,ifid,idex,exmem,memwb, ifid_f,idex_f,exmem_f, md_busy,md_done}
  localparam logic [9:0] DEF  = 10'b11111_000_00;
  localparam logic [9:0] FRZ  = 10'b00000_000_00;
  localparam logic [9:0] FRZB = 10'b00000_000_10;
  localparam logic [9:0] LU   = 10'b00111_010_00;
  localparam logic [9:0] BR   = 10'b11111_110_00;
  localparam logic [9:0] MDS0 = 10'b00011_001_00;
  localparam logic [9:0] MDS1 = 10'b00011_001_10;
  localparam logic [9:0] REL  = 10'b11111_000_11;
  localparam logic [9:0] RSTV = 10'b00000_000_00;

  logic clk = 1'b0;
  logic rst;
  in_t  cur;
  logic pc_wr_en, ifid_wr_en, idex_wr_en, exmem_wr_en, memwb_wr_en;
  logic ifid_flush, idex_flush, exmem_flush, md_busy, md_done;
  logic [31:0] stall_cnt;
  logic [9:0]  outv;

  int n_tests = 0, n_fail = 0;
  int age = 0;            // model: 0 = no op, else elapsed unfrozen cycles of the op
  int unsigned scnt = 0;  // model stall counter

  always #5 clk = ~clk;

  hazard_ctrl #(.MD_CYCLES(MD), .REG_ADDR_W(5), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(cur.rs1), .id_rs2(cur.rs2), .id_use_rs1(cur.use1), .id_use_rs2(cur.use2),
    .ex_rd(cur.rd), .ex_mem_read(cur.mem_read), .ex_md_start(cur.md_start),
    .ex_branch_taken(cur.br), .mem_req(cur.mem_req), .dmem_ready(cur.dready),
    .pc_wr_en(pc_wr_en), .ifid_wr_en(ifid_wr_en), .idex_wr_en(idex_wr_en),
    .exmem_wr_en(exmem_wr_en), .memwb_wr_en(memwb_wr_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .md_busy(md_busy), .md_done(md_done), .stall_cnt(stall_cnt)
  );

  assign outv = {pc_wr_en, ifid_wr_en, idex_wr_en, exmem_wr_en, memwb_wr_en,
                 ifid_flush, idex_flush, exmem_flush, md_busy, md_done};

  function automatic in_t mk(input logic [4:0] rs1, rs2, input logic u1, u2,
                             input logic [4:0] rd, input logic mr, ms, br, mq, dr);
    in_t x;
    x.rs1 = rs1; x.rs2 = rs2; x.use1 = u1; x.use2 = u2; x.rd = rd;
    x.mem_read = mr; x.md_start = ms; x.br = br; x.mem_req = mq; x.dready = dr;
    return x;
  endfunction

  // Reference model: outputs follow the priority rules from the model's op age.
  function automatic logic [9:0] model_out(input logic r, input in_t x);
    logic busy, frz, lu;
    if (!r) return RSTV;
    busy = (age != 0);
    frz  = x.mem_req && !x.dready;
    lu   = x.mem_read && x.rd != 0 &&
           ((x.use1 && x.rs1 == x.rd) || (x.use2 && x.rs2 == x.rd));
    if (frz) return busy ? FRZB : FRZ;
    if (!busy && x.md_start) return MDS0;
    if (busy && age < MD - 1) return MDS1;
    if (busy) return REL;
    if (x.br) return BR;
    if (lu) return LU;
    return DEF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One cycle: drive, sample at negedge against model (and optional constant), advance model.
  task automatic step(input in_t x, input logic [9:0] exp, input bit use_exp, input string nm);
    logic [9:0] m;
    logic frz;
    cur = x;
    @(negedge clk);
    m = model_out(rst, x);
    chk({nm, "/model"}, {22'd0, outv}, {22'd0, m});
    chk({nm, "/stall_cnt"}, stall_cnt, scnt);
    if (use_exp) chk({nm, "/vec"}, {22'd0, outv}, {22'd0, exp});
    @(posedge clk);
    frz = x.mem_req && !x.dready;
    if (!rst) begin
      age = 0; scnt = 0;
    end else begin
      if (!m[9]) scnt++;
      if (!frz) begin
        if (age == 0 && x.md_start) age = 1;
        else if (age != 0) age = (age == MD - 1) ? 0 : age + 1;
      end
    end
    #1;
  endtask

  vec_t tbl[12];
  in_t  idle, mds, mdf;
  int unsigned c0;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mds  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    mdf  = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    tbl[0]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), DEF, "idle"};
    tbl[1]  = '{mk(1, 5, 1, 1, 5, 1, 0, 0, 0, 0), LU,  "lu_rs2"};
    tbl[2]  = '{mk(0, 0, 1, 1, 0, 1, 0, 0, 0, 0), DEF, "lu_rd0"};
    tbl[3]  = '{mk(7, 2, 0, 1, 7, 1, 0, 0, 0, 0), DEF, "lu_nouse"};
    tbl[4]  = '{mk(7, 2, 1, 0, 7, 1, 0, 0, 0, 0), LU,  "lu_rs1"};
    tbl[5]  = '{mk(3, 3, 1, 1, 3, 1, 0, 1, 0, 0), BR,  "br_lu"};
    tbl[6]  = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), BR,  "br"};
    tbl[7]  = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0), FRZ, "frz_br"};
    tbl[8]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1), DEF, "mem_rdy"};
    tbl[9]  = '{mk(4, 4, 1, 1, 4, 0, 0, 0, 0, 0), DEF, "no_load"};
    tbl[10] = '{mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0), FRZ, "frz_md"};
    tbl[11] = '{mk(6, 0, 1, 0, 6, 1, 0, 0, 1, 0), FRZ, "frz_lu"};

    // Reset held two cycles, then release
    rst = 1'b0;
    step(idle, RSTV, 1, "rst0");
    step(idle, RSTV, 1, "rst1");
    rst = 1'b1;
    chk("rst_cnt", stall_cnt, 32'd0);
    step(idle, DEF, 1, "post_rst");

    for (int i = 0; i < 12; i++) step(tbl[i].i, tbl[i].e, 1, tbl[i].nm);

    c0 = stall_cnt;
    step(tbl[1].i, LU, 1, "lu_cnt");
    chk("lu_cnt_inc", stall_cnt, c0 + 1);

    // Full mul/div op
    c0 = stall_cnt;
    step(mds, MDS0, 1, "md_s0");
    step(mds, MDS1, 1, "md_s1");
    step(mds, MDS1, 1, "md_s2");
    step(mds, REL,  1, "md_rel");
    step(idle, DEF, 1, "md_after");
    chk("md_cnt3", stall_cnt, c0 + 3);

    // Freeze on the second stall cycle stretches the op by two
    c0 = stall_cnt;
    step(mds, MDS0, 1, "mdf_s0");
    step(mdf, FRZB, 1, "mdf_f0");
    step(mdf, FRZB, 1, "mdf_f1");
    step(mds, MDS1, 1, "mdf_s1");
    step(mds, MDS1, 1, "mdf_s2");
    step(mds, REL,  1, "mdf_rel");
    chk("mdf_cnt5", stall_cnt, c0 + 5);

    // Branch under freeze waits for dmem_ready
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0), FRZ, 1, "brf_frz");
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1), BR,  1, "brf_rdy");

    // Reset mid-op, then a fresh op runs full length
    step(mds, MDS0, 1, "rmd_s0");
    step(mds, MDS1, 1, "rmd_s1");
    rst = 1'b0;
    step(mds, RSTV, 1, "rmd_rst");
    rst = 1'b1;
    chk("rmd_cnt0", stall_cnt, 32'd0);
    chk("rmd_busy0", {31'd0, md_busy}, 32'd0);
    step(mds, MDS0, 1, "rmd2_s0");
    step(mds, MDS1, 1, "rmd2_s1");
    step(mds, MDS1, 1, "rmd2_s2");
    step(mds, REL,  1, "rmd2_rel");

    // Random traffic vs model
    for (int n = 0; n < 600; n++) begin
      in_t x;
      x.rs1 = 5'($urandom_range(0, 3)); x.rs2 = 5'($urandom_range(0, 3));
      x.rd  = 5'($urandom_range(0, 3));
      x.use1 = 1'($urandom); x.use2 = 1'($urandom); x.mem_read = 1'($urandom);
      x.md_start = ($urandom_range(0, 3) == 0);
      x.br       = ($urandom_range(0, 3) == 0);
      x.mem_req  = ($urandom_range(0, 2) == 0);
      x.dready   = 1'($urandom);
      rst = ($urandom_range(0, 59) != 0);
      step(x, DEF, 0, "rand");
    end
    rst = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
